// File: rtl/neuron_sched_pkg.sv
// Shared types and constants for the neuron layer scheduler.
// The optional per-neuron watchdog is enabled by defining NEURON_SCHED_TIMEOUT_EN.
package neuron_sched_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_STORE  = 3'd3,
        S_DONE   = 3'd4
    } sched_state_e;

    // Neuron index width; a single-neuron layer still gets a 1-bit index.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/neuron_sched_watchdog.sv
// WAIT-cycle counter for one neuron evaluation; flags expiry on the
// TIMEOUT_CYCLES-th consecutive WAIT cycle. Used only with NEURON_SCHED_TIMEOUT_EN.
module neuron_sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = run_i && (cnt_q == LIMIT);

    // Next count: restart on launch, advance while waiting, saturate at expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/neuron_layer_scheduler.sv
// Time-multiplexes one neuron datapath across NEURON_COUNT logical neurons.
// Define NEURON_SCHED_TIMEOUT_EN to add the per-neuron watchdog and timeout_err.
module neuron_layer_scheduler
    import neuron_sched_pkg::*;
#(
    parameter int NEURON_COUNT   = 4,
    parameter int INPUT_COUNT    = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  layer_start,
    input  logic [INPUT_COUNT*8-1:0]              layer_inputs,
    input  logic [NEURON_COUNT*INPUT_COUNT*8-1:0] layer_weights,
    output logic [INPUT_COUNT*8-1:0]              nrn_inputs,
    output logic [INPUT_COUNT*8-1:0]              nrn_weights,
    output logic                                  nrn_start,
    input  logic [7:0]                            nrn_out,
    input  logic                                  nrn_ready,
    output logic [NEURON_COUNT*8-1:0]             layer_out,
    output logic                                  layer_done,
    output logic                                  busy,
    output logic                                  timeout_err
);

    localparam int IW = idx_width(NEURON_COUNT);
    localparam int VW = INPUT_COUNT * DATA_W;
    localparam int LW = NEURON_COUNT * VW;
    localparam logic [IW-1:0] LAST_IDX = IW'(NEURON_COUNT - 1);

    sched_state_e                     state_q, state_d;
    logic [IW-1:0]                    idx_q, idx_d;
    logic [VW-1:0]                    inputs_q, inputs_d;
    logic [LW-1:0]                    weights_q, weights_d;
    logic [NEURON_COUNT*DATA_W-1:0]   layer_out_q, layer_out_d;
    logic                             blank_q, blank_d;
    logic                             nrn_start_q;
    logic                             busy_q;
    logic                             done_q;
    logic                             wd_expired_s;
    logic                             accept_s;

    assign accept_s    = (state_q == S_IDLE) && layer_start;
    assign nrn_inputs  = inputs_q;
    assign nrn_weights = weights_q[idx_q*VW +: VW];
    assign nrn_start   = nrn_start_q;
    assign layer_out   = layer_out_q;
    assign layer_done  = done_q;
    assign busy        = busy_q;

`ifdef NEURON_SCHED_TIMEOUT_EN
    logic err_q;

    neuron_sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_q == S_LAUNCH),
        .run_i    (state_q == S_WAIT),
        .expired_o(wd_expired_s)
    );

    // Sticky timeout flag, cleared when a new layer is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept_s) begin
            err_q <= 1'b0;
        end else if (wd_expired_s && !(blank_q && nrn_ready)) begin
            err_q <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end

    assign timeout_err = err_q;
`else
    assign wd_expired_s = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // Next-state, snapshot capture and activation collection.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        inputs_d    = inputs_q;
        weights_d   = weights_q;
        layer_out_d = layer_out_q;
        blank_d     = blank_q;
        case (state_q)
            S_IDLE: begin
                if (layer_start) begin
                    inputs_d  = layer_inputs;
                    weights_d = layer_weights;
                    idx_d     = '0;
                    state_d   = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                blank_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The first WAIT cycle may still see the previous neuron's ready.
                blank_d = 1'b1;
                if (blank_q && nrn_ready) begin
                    state_d = S_STORE;
                end else if (wd_expired_s) begin
                    layer_out_d[idx_q*DATA_W +: DATA_W] = 8'h00;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_LAUNCH;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_STORE: begin
                layer_out_d[idx_q*DATA_W +: DATA_W] = nrn_out;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_LAUNCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, snapshot and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            inputs_q    <= '0;
            weights_q   <= '0;
            layer_out_q <= '0;
            blank_q     <= 1'b0;
            nrn_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            inputs_q    <= inputs_d;
            weights_q   <= weights_d;
            layer_out_q <= layer_out_d;
            blank_q     <= blank_d;
            nrn_start_q <= (state_d == S_LAUNCH);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Directed self-checking bench for neuron_layer_scheduler with a stub datapath.
module tb_neuron_layer_scheduler;

    localparam int NC = 4;
    localparam int IC = 8;
    localparam int TO = 8;

    logic              clk;
    logic              rst_n;
    logic              layer_start;
    logic [IC*8-1:0]   layer_inputs;
    logic [NC*IC*8-1:0] layer_weights;
    logic [IC*8-1:0]   nrn_inputs;
    logic [IC*8-1:0]   nrn_weights;
    logic              nrn_start;
    logic [7:0]        nrn_out;
    logic              nrn_ready;
    logic [NC*8-1:0]   layer_out;
    logic              layer_done;
    logic              busy;
    logic              timeout_err;

    int checks;
    int errors;
    int done_cnt;
    int stub_mode;
    logic [3:0] stub_cnt;
    logic [3:0] stub_last;

    neuron_layer_scheduler #(
        .NEURON_COUNT  (NC),
        .INPUT_COUNT   (IC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .layer_start  (layer_start),
        .layer_inputs (layer_inputs),
        .layer_weights(layer_weights),
        .nrn_inputs   (nrn_inputs),
        .nrn_weights  (nrn_weights),
        .nrn_start    (nrn_start),
        .nrn_out      (nrn_out),
        .nrn_ready    (nrn_ready),
        .layer_out    (layer_out),
        .layer_done   (layer_done),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub datapath: mode 0 ready 3 cycles after start; mode 1 stale ready
    // through LAUNCH and first WAIT, then low 2 cycles; mode 2 never readies neuron 1.
    assign stub_last = (stub_mode == 1) ? 4'd4 : 4'd3;
    assign nrn_out   = nrn_weights[7:0] ^ nrn_inputs[7:0];
    assign nrn_ready = (stub_mode == 1) ? (stub_cnt == 4'd0 || stub_cnt == 4'd1 || stub_cnt == 4'd4)
                     : (stub_mode == 2) ? (stub_cnt == 4'd3 && nrn_weights[7:0] != 8'h11)
                     : (stub_cnt == 4'd3);

    always @(posedge clk) begin
        if (nrn_start) begin
            stub_cnt <= 4'd1;
        end else if (stub_cnt != 4'd0 && stub_cnt != stub_last) begin
            stub_cnt <= stub_cnt + 4'd1;
        end else begin
            stub_cnt <= 4'd0;
        end
    end

    always @(posedge clk) begin
        if (layer_done) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept a layer, optionally poke layer_start at cycle `poke`, and
    // return the number of cycles from accept to layer_done.
    task automatic run_layer(input int poke, output int lat);
        @(negedge clk);
        layer_start = 1'b1;
        @(posedge clk);
        #1;
        layer_start = 1'b0;
        lat = 1;
        check("launch_busy", {63'd0, busy}, 64'd1);
        check("launch_start", {63'd0, nrn_start}, 64'd1);
        while (!layer_done && lat < 300) begin
            if (lat == poke) begin
                layer_inputs = {{(IC*8-8){1'b1}}, 8'hFF};
                layer_start  = 1'b1;
            end else if (lat == poke + 1) begin
                layer_start = 1'b0;
            end else begin
                layer_start = layer_start;
            end
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        layer_start = 1'b0;
    endtask

    int lat;
    int d0;

    initial begin
        checks       = 0;
        errors       = 0;
        done_cnt     = 0;
        stub_mode    = 0;
        stub_cnt     = 4'd0;
        layer_start  = 1'b0;
        layer_inputs = '0;
        for (int n = 0; n < NC; n++) begin
            for (int b = 0; b < IC; b++) begin
                layer_weights[(n*IC+b)*8 +: 8] = (b == 0) ? 8'(8'h10 + n) : 8'(8'hA0 + n*8 + b);
            end
        end
        rst_n = 1'b0;
        #23;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_start", {63'd0, nrn_start}, 64'd0);
        check("rst_done", {63'd0, layer_done}, 64'd0);
        check("rst_err", {63'd0, timeout_err}, 64'd0);
        check("rst_out", {32'd0, layer_out}, 64'd0);
        check("rst_inputs", nrn_inputs, 64'd0);
        check("rst_weights", nrn_weights, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic run: four neurons, W=3.
        d0 = done_cnt;
        run_layer(0, lat);
        check("basic_latency", 64'(lat), 64'd21);
        check("basic_out", {32'd0, layer_out}, 64'h13121110);
        repeat (3) @(posedge clk);
        #1;
        check("basic_done_once", 64'(done_cnt - d0), 64'd1);
        check("basic_idle_busy", {63'd0, busy}, 64'd0);

        // Stale ready: W=4, value taken only after the real ready.
        stub_mode    = 1;
        layer_inputs = 64'h01;
        run_layer(0, lat);
        check("stale_latency", 64'(lat), 64'd25);
        check("stale_out", {32'd0, layer_out}, 64'h12131011);
        stub_mode = 0;
        repeat (3) @(posedge clk);

        // layer_start mid-run with different inputs must be ignored.
        d0           = done_cnt;
        layer_inputs = 64'h02;
        run_layer(7, lat);
        check("busy_start_latency", 64'(lat), 64'd21);
        check("busy_start_out", {32'd0, layer_out}, 64'h11101312);
        check("busy_start_snapshot", nrn_inputs, 64'h02);
        repeat (3) @(posedge clk);
        #1;
        check("busy_start_done_once", 64'(done_cnt - d0), 64'd1);

        // Back-to-back with layer_start held high.
        d0           = done_cnt;
        layer_inputs = 64'h03;
        @(negedge clk);
        layer_start = 1'b1;
        lat = 0;
        @(posedge clk);
        #1;
        while (!layer_done && lat < 300) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        check("b2b_first_out", {32'd0, layer_out}, 64'h10111213);
        @(posedge clk);
        #1;
        check("b2b_gap_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        check("b2b_restart_busy", {63'd0, busy}, 64'd1);
        check("b2b_restart_start", {63'd0, nrn_start}, 64'd1);
        layer_start = 1'b0;
        lat = 0;
        while (!layer_done && lat < 300) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        check("b2b_second_latency", 64'(lat), 64'd20);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_done_count", 64'(done_cnt - d0), 64'd2);

        // Reset in WAIT of neuron 2, then a clean run.
        layer_inputs = 64'h00;
        @(negedge clk);
        layer_start = 1'b1;
        @(posedge clk);
        #1;
        layer_start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_start", {63'd0, nrn_start}, 64'd0);
        check("midrst_done", {63'd0, layer_done}, 64'd0);
        check("midrst_out", {32'd0, layer_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        run_layer(0, lat);
        check("postrst_latency", 64'(lat), 64'd21);
        check("postrst_out", {32'd0, layer_out}, 64'h13121110);
        repeat (3) @(posedge clk);

`ifdef NEURON_SCHED_TIMEOUT_EN
        // Neuron 1 never readies: its slice is zeroed and the error sticks.
        d0        = done_cnt;
        stub_mode = 2;
        run_layer(0, lat);
        check("to_done_reached", {63'd0, layer_done}, 64'd1);
        check("to_out", {32'd0, layer_out}, 64'h13120010);
        check("to_err", {63'd0, timeout_err}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("to_err_sticky", {63'd0, timeout_err}, 64'd1);
        check("to_done_once", 64'(done_cnt - d0), 64'd1);
        stub_mode = 0;
        run_layer(0, lat);
        check("to_err_cleared", {63'd0, timeout_err}, 64'd0);
        check("to_clean_out", {32'd0, layer_out}, 64'h13121110);
`else
        check("no_timeout_err", {63'd0, timeout_err}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
